// File: rtl/mem_stage_hs_pkg.sv
// Shared widths, load-type bit indices and bus layouts for the MEM stage.
// Buses stay flat vectors on the ports and are viewed through these structs inside.
package mem_stage_hs_pkg;

    localparam int unsigned ES_TO_MS_BUS_WD   = 79;
    localparam int unsigned MS_TO_WS_BUS_WD   = 73;
    localparam int unsigned STALL_MS_BUS_WD   = 11;
    localparam int unsigned FORWARD_MS_BUS_WD = 33;

    // Bit positions inside the one-hot inst_load field
    typedef enum int unsigned {
        LD_LB  = 0,
        LD_LBU = 1,
        LD_LH  = 2,
        LD_LHU = 3,
        LD_LW  = 4,
        LD_LWL = 5,
        LD_LWR = 6
    } ld_bit_e;

    typedef struct packed {
        logic        is_mem;
        logic        res_from_mem;
        logic [6:0]  inst_load;
        logic        gr_we_1;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic [3:0]  gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_hs_if.sv
// Handshake, payload, SRAM-response and hazard buses around the MEM stage.
// slave is the stage itself; master is everything driving it (EX, WB, SRAM, ID).
interface mem_stage_hs_if;
    import mem_stage_hs_pkg::*;

    logic                         ws_allowin;
    logic                         ms_allowin;
    logic                         es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus;
    logic                         ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus;
    logic                         flush;
    logic                         data_sram_data_ok;
    logic [31:0]                  data_sram_rdata;
    logic [STALL_MS_BUS_WD-1:0]   stall_ms_bus;
    logic [FORWARD_MS_BUS_WD-1:0] forward_ms_bus;

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus, flush,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               stall_ms_bus, forward_ms_bus
    );

    modport master (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus, flush,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               stall_ms_bus, forward_ms_bus
    );

endinterface

// File: rtl/mem_stage_hs_load_align.sv
// Load data alignment and extension, including the partial-word LWL/LWR merges.
// Produces the per-byte register write enables that let WB merge LWL/LWR results.
module ms_load_align
    import mem_stage_hs_pkg::*;
(
    input  logic [6:0]  inst_load,
    input  logic [1:0]  addr,
    input  logic        gr_we_1,
    input  logic [31:0] rdata,
    output logic [3:0]  gr_we,
    output logic [31:0] aligned_ld
);

    logic [31:0] shr_data;
    logic [31:0] shl_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign shr_data = rdata >> {addr, 3'b000};
    assign shl_data = rdata << {~addr, 3'b000};
    assign byte_sel = shr_data[7:0];
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        aligned_ld = rdata;
        gr_we      = 4'b1111;
        if (inst_load[LD_LB]) begin
            aligned_ld = {{24{byte_sel[7]}}, byte_sel};
        end else if (inst_load[LD_LBU]) begin
            aligned_ld = {24'h0, byte_sel};
        end else if (inst_load[LD_LH]) begin
            aligned_ld = {{16{half_sel[15]}}, half_sel};
        end else if (inst_load[LD_LHU]) begin
            aligned_ld = {16'h0, half_sel};
        end else if (inst_load[LD_LWL]) begin
            aligned_ld = shl_data;
            case (addr)
                2'd0:    gr_we = 4'b1000;
                2'd1:    gr_we = 4'b1100;
                2'd2:    gr_we = 4'b1110;
                default: gr_we = 4'b1111;
            endcase
        end else if (inst_load[LD_LWR]) begin
            aligned_ld = shr_data;
            case (addr)
                2'd0:    gr_we = 4'b1111;
                2'd1:    gr_we = 4'b0111;
                2'd2:    gr_we = 4'b0011;
                default: gr_we = 4'b0001;
            endcase
        end
        if (!gr_we_1) begin
            gr_we = '0;
        end
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM stage of the 5-stage MIPS pipeline on a handshaked data SRAM.
// Holds the EX entry until its data_ok, buffers early responses, drops responses of flushed loads.
module mem_stage_hs
    import mem_stage_hs_pkg::*;
#(
    parameter int unsigned CANCEL_W = 2
)
(
    input  logic          clk,
    input  logic          reset,
    mem_stage_hs_if.slave hs
);

    es_to_ms_t           bus_r;
    ms_to_ws_t           ws_out;
    logic                ms_valid;
    logic                rbuf_valid;
    logic [31:0]         rbuf;
    logic [CANCEL_W-1:0] cancel_cnt;

    logic                resp;
    logic                ms_ready_go;
    logic                ms_allowin;
    logic                ms_to_ws_valid;
    logic                ms_leave;
    logic                cancel_inc;
    logic                cancel_dec;
    logic                res_pending;
    logic [31:0]         ld_data;
    logic [31:0]         aligned_ld;
    logic [31:0]         final_result;
    logic [3:0]          gr_we;

    // A data_ok seen while kills are outstanding belongs to a flushed entry
    assign resp       = hs.data_sram_data_ok && (cancel_cnt == '0);
    assign cancel_dec = hs.data_sram_data_ok && (cancel_cnt != '0);
    assign cancel_inc = hs.flush && ms_valid && bus_r.is_mem && !rbuf_valid && !resp;

    assign ms_ready_go    = !bus_r.is_mem || rbuf_valid || resp;
    assign ms_allowin     = !ms_valid || (ms_ready_go && hs.ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !hs.flush;
    assign ms_leave       = ms_to_ws_valid && hs.ws_allowin;
    assign res_pending    = ms_valid && bus_r.res_from_mem && !ms_ready_go;
    assign ld_data        = rbuf_valid ? rbuf : hs.data_sram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (hs.flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= hs.es_to_ms_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_r <= '0;
        end else if (hs.es_to_ms_valid && ms_allowin) begin
            bus_r <= hs.es_to_ms_bus;
        end
    end

    // Catch a response that arrives while WB is blocked; the SRAM won't repeat it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rbuf_valid <= 1'b0;
            rbuf       <= '0;
        end else if (hs.flush || ms_leave) begin
            rbuf_valid <= 1'b0;
        end else if (resp && ms_valid && bus_r.is_mem && !hs.ws_allowin && !rbuf_valid) begin
            rbuf_valid <= 1'b1;
            rbuf       <= hs.data_sram_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cancel_cnt <= '0;
        end else begin
            cancel_cnt <= cancel_cnt + CANCEL_W'(cancel_inc) - CANCEL_W'(cancel_dec);
        end
    end

    cancel_cnt_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(cancel_inc && !cancel_dec && (cancel_cnt == '1)));

    ms_load_align u_align (
        .inst_load  (bus_r.inst_load),
        .addr       (bus_r.alu_result[1:0]),
        .gr_we_1    (bus_r.gr_we_1),
        .rdata      (ld_data),
        .gr_we      (gr_we),
        .aligned_ld (aligned_ld)
    );

    assign final_result = bus_r.res_from_mem ? aligned_ld : bus_r.alu_result;

    always_comb begin
        ws_out              = '0;
        ws_out.gr_we        = gr_we;
        ws_out.dest         = bus_r.dest;
        ws_out.final_result = final_result;
        ws_out.pc           = bus_r.pc;
    end

    assign hs.ms_allowin     = ms_allowin;
    assign hs.ms_to_ws_valid = ms_to_ws_valid;
    assign hs.ms_to_ws_bus   = ws_out;
    assign hs.stall_ms_bus   = {res_pending, ms_valid & bus_r.gr_we_1,
                                {4{ms_valid}} & gr_we, bus_r.dest};
    assign hs.forward_ms_bus = {ms_valid & ms_ready_go, final_result};

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed and randomized checks of mem_stage_hs against a transaction-level reference model.
module tb_mem_stage_hs;
    import mem_stage_hs_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_hs_if hs ();

    mem_stage_hs #(.CANCEL_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .hs    (hs)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic es_to_ms_t mk(input logic is_mem, input logic rfm, input int unsigned ld_idx,
                                     input logic we1, input logic [4:0] dest,
                                     input logic [31:0] alu, input logic [31:0] pc);
        es_to_ms_t e;
        e.is_mem       = is_mem;
        e.res_from_mem = rfm;
        e.inst_load    = rfm ? 7'(1 << ld_idx) : 7'h0;
        e.gr_we_1      = we1;
        e.dest         = dest;
        e.alu_result   = alu;
        e.pc           = pc;
        return e;
    endfunction

    function automatic es_to_ms_t mk_lw(input logic [31:0] alu, input logic [4:0] dest, input logic [31:0] pc);
        return mk(1'b1, 1'b1, LD_LW, 1'b1, dest, alu, pc);
    endfunction

    // Reference: WB payload from the architectural load/store rules
    function automatic logic [72:0] model(input es_to_ms_t e, input logic [31:0] rd);
        int unsigned a;
        logic [31:0] v;
        logic [3:0]  we;
        a  = 32'(e.alu_result[1:0]);
        v  = rd;
        we = 4'hF;
        if (e.inst_load[0])      v = 32'($signed(rd[8*a +: 8]));
        else if (e.inst_load[1]) v = {24'h0, rd[8*a +: 8]};
        else if (e.inst_load[2]) v = 32'($signed(rd[16*(a/2) +: 16]));
        else if (e.inst_load[3]) v = {16'h0, rd[16*(a/2) +: 16]};
        else if (e.inst_load[5]) begin v = rd << (8*(3-a)); we = 4'hF << (3-a); end
        else if (e.inst_load[6]) begin v = rd >> (8*a);     we = 4'hF >> a;     end
        if (!e.gr_we_1) we = 4'h0;
        return {we, e.dest, (e.res_from_mem ? v : e.alu_result), e.pc};
    endfunction

    function automatic es_to_ms_t rnd_entry();
        es_to_ms_t e;
        int unsigned kind;
        int unsigned idx;
        kind = $urandom_range(0, 9);
        idx  = $urandom_range(0, 6);
        e = mk(1'b0, 1'b0, 0, 1'($urandom), 5'($urandom), $urandom, $urandom);
        if (kind == 3) begin
            e.is_mem  = 1'b1;
            e.gr_we_1 = 1'b0;
        end else if (kind > 3) begin
            e = mk(1'b1, 1'b1, idx, 1'($urandom), e.dest, e.alu_result, e.pc);
            if (idx == LD_LH || idx == LD_LHU) e.alu_result[0] = 1'b0;
        end
        return e;
    endfunction

    task automatic send(input es_to_ms_t e);
        hs.es_to_ms_valid = 1'b1;
        hs.es_to_ms_bus   = e;
        #2;
        chk("send_allowin", 73'(hs.ms_allowin), 73'(1));
        cyc();
        hs.es_to_ms_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    int unsigned al_idx [6] = '{LD_LB, LD_LHU, LD_LWL, LD_LWR, LD_LH, LD_LBU};
    logic [31:0] al_addr[6] = '{32'h41, 32'h42, 32'h41, 32'h41, 32'h40, 32'h43};
    logic [31:0] al_res [6] = '{32'hFFFFFFAA, 32'h00008899, 32'hAABB0000, 32'h008899AA,
                                32'hFFFFAABB, 32'h00000088};
    logic [3:0]  al_we  [6] = '{4'b1111, 4'b1111, 4'b1100, 4'b0111, 4'b1111, 4'b1111};

    es_to_ms_t   cur;
    logic [31:0] cur_rd;
    logic [31:0] respq[$];
    logic [72:0] expq[$];

    initial begin
        reset                = 1'b1;
        hs.ws_allowin        = 1'b1;
        hs.es_to_ms_valid    = 1'b0;
        hs.es_to_ms_bus      = '0;
        hs.flush             = 1'b0;
        hs.data_sram_data_ok = 1'b0;
        hs.data_sram_rdata   = '0;
        cyc();
        cyc();
        #2;
        chk("rst_valid",   73'(hs.ms_to_ws_valid), 73'(0));
        chk("rst_allowin", 73'(hs.ms_allowin), 73'(1));
        chk("rst_stall",   73'(hs.stall_ms_bus[10:5]), 73'(0));
        chk("rst_fwd",     73'(hs.forward_ms_bus[32]), 73'(0));
        cyc();
        reset = 1'b0;

        // Load stall: response three cycles after issue
        send(mk_lw(32'h100, 5'd5, 32'h1000));
        for (int k = 0; k < 2; k++) begin
            #2;
            chk("ldstall_wait_valid", 73'(hs.ms_to_ws_valid), 73'(0));
            chk("ldstall_pending",    73'(hs.stall_ms_bus[10]), 73'(1));
            cyc();
        end
        hs.data_sram_data_ok = 1'b1;
        hs.data_sram_rdata   = 32'h11223344;
        #2;
        chk("ldstall_valid", 73'(hs.ms_to_ws_valid), 73'(1));
        chk("ldstall_bus",   hs.ms_to_ws_bus, {4'hF, 5'd5, 32'h11223344, 32'h1000});
        chk("ldstall_fwd",   73'(hs.forward_ms_bus), 73'({1'b1, 32'h11223344}));
        chk("ldstall_nopend", 73'(hs.stall_ms_bus[10]), 73'(0));
        cyc();
        hs.data_sram_data_ok = 1'b0;
        #2;
        chk("ldstall_gone",    73'(hs.ms_to_ws_valid), 73'(0));
        chk("ldstall_allowin", 73'(hs.ms_allowin), 73'(1));
        cyc();

        // Alignment cases on rdata 0x8899AABB
        for (int i = 0; i < 6; i++) begin
            send(mk(1'b1, 1'b1, al_idx[i], 1'b1, 5'd7, al_addr[i], 32'h1100 + 32'(i)));
            hs.data_sram_data_ok = 1'b1;
            hs.data_sram_rdata   = 32'h8899AABB;
            #2;
            chk($sformatf("align_%0d", i), hs.ms_to_ws_bus,
                {al_we[i], 5'd7, al_res[i], 32'h1100 + 32'(i)});
            cyc();
            hs.data_sram_data_ok = 1'b0;
        end

        // Store: waits for its data_ok, writes nothing back
        send(mk(1'b1, 1'b0, 0, 1'b0, 5'd3, 32'h0000ABC4, 32'h1800));
        #2;
        chk("store_wait", 73'(hs.ms_to_ws_valid), 73'(0));
        cyc();
        hs.data_sram_data_ok = 1'b1;
        hs.data_sram_rdata   = 32'h5A5A5A5A;
        #2;
        chk("store_bus", hs.ms_to_ws_bus, {4'h0, 5'd3, 32'h0000ABC4, 32'h1800});
        cyc();
        hs.data_sram_data_ok = 1'b0;

        // Early response while WB is blocked for two cycles
        send(mk_lw(32'h200, 5'd9, 32'h2000));
        hs.ws_allowin        = 1'b0;
        hs.data_sram_data_ok = 1'b1;
        hs.data_sram_rdata   = 32'hCAFEBABE;
        #2;
        chk("early_bus0", hs.ms_to_ws_bus, {4'hF, 5'd9, 32'hCAFEBABE, 32'h2000});
        cyc();
        hs.data_sram_data_ok = 1'b0;
        hs.data_sram_rdata   = 32'h0BADF00D;
        #2;
        chk("early_valid1", 73'(hs.ms_to_ws_valid), 73'(1));
        chk("early_bus1",   hs.ms_to_ws_bus, {4'hF, 5'd9, 32'hCAFEBABE, 32'h2000});
        cyc();
        hs.ws_allowin = 1'b1;
        #2;
        chk("early_bus2",    hs.ms_to_ws_bus, {4'hF, 5'd9, 32'hCAFEBABE, 32'h2000});
        chk("early_allowin", 73'(hs.ms_allowin), 73'(1));
        cyc();
        #2;
        chk("early_once", 73'(hs.ms_to_ws_valid), 73'(0));
        cyc();

        // Flush before data_ok: next response is the killed load's and must be dropped
        send(mk_lw(32'h300, 5'd10, 32'h3000));
        cyc();
        hs.flush = 1'b1;
        #2;
        chk("flush_mask", 73'(hs.ms_to_ws_valid), 73'(0));
        cyc();
        hs.flush = 1'b0;
        send(mk_lw(32'h304, 5'd11, 32'h3004));
        hs.data_sram_data_ok = 1'b1;
        hs.data_sram_rdata   = 32'h00000BAD;
        #2;
        chk("cancel_drop",    73'(hs.ms_to_ws_valid), 73'(0));
        chk("cancel_pending", 73'(hs.stall_ms_bus[10]), 73'(1));
        cyc();
        hs.data_sram_rdata = 32'h600D600D;
        #2;
        chk("cancel_credit", hs.ms_to_ws_bus, {4'hF, 5'd11, 32'h600D600D, 32'h3004});
        chk("cancel_valid",  73'(hs.ms_to_ws_valid), 73'(1));
        cyc();
        hs.data_sram_data_ok = 1'b0;

        // Flush coinciding with data_ok: response is consumed, no pending kill
        send(mk_lw(32'h400, 5'd12, 32'h4000));
        hs.flush             = 1'b1;
        hs.data_sram_data_ok = 1'b1;
        hs.data_sram_rdata   = 32'hDEAD0000;
        #2;
        chk("flushresp_mask", 73'(hs.ms_to_ws_valid), 73'(0));
        cyc();
        hs.flush             = 1'b0;
        hs.data_sram_data_ok = 1'b0;
        send(mk_lw(32'h404, 5'd13, 32'h4004));
        hs.data_sram_data_ok = 1'b1;
        hs.data_sram_rdata   = 32'h12345678;
        #2;
        chk("flushresp_next", hs.ms_to_ws_bus, {4'hF, 5'd13, 32'h12345678, 32'h4004});
        chk("flushresp_valid", 73'(hs.ms_to_ws_valid), 73'(1));
        cyc();
        hs.data_sram_data_ok = 1'b0;

        // Async reset while a load waits with a kill outstanding
        send(mk_lw(32'h500, 5'd14, 32'h5000));
        hs.flush = 1'b1;
        cyc();
        hs.flush = 1'b0;
        send(mk_lw(32'h504, 5'd15, 32'h5004));
        #2;
        chk("prerst_pending", 73'(hs.stall_ms_bus[10]), 73'(1));
        reset = 1'b1;
        #1;
        chk("arst_valid",   73'(hs.ms_to_ws_valid), 73'(0));
        chk("arst_allowin", 73'(hs.ms_allowin), 73'(1));
        chk("arst_stall",   73'(hs.stall_ms_bus[10:5]), 73'(0));
        chk("arst_fwd",     73'(hs.forward_ms_bus[32]), 73'(0));
        cyc();
        reset = 1'b0;
        send(mk_lw(32'h508, 5'd16, 32'h5008));
        hs.data_sram_data_ok = 1'b1;
        hs.data_sram_rdata   = 32'h00000077;
        #2;
        chk("arst_credit", hs.ms_to_ws_bus, {4'hF, 5'd16, 32'h00000077, 32'h5008});
        chk("arst_credit_valid", 73'(hs.ms_to_ws_valid), 73'(1));
        cyc();
        hs.data_sram_data_ok = 1'b0;

        // Randomized traffic against the reference model
        cur    = rnd_entry();
        cur_rd = $urandom;
        for (int c = 0; c < 700; c++) begin
            hs.ws_allowin = ($urandom_range(0, 3) != 0);
            if (respq.size() != 0 && $urandom_range(0, 2) == 0) begin
                hs.data_sram_data_ok = 1'b1;
                hs.data_sram_rdata   = respq.pop_front();
            end else begin
                hs.data_sram_data_ok = 1'b0;
                hs.data_sram_rdata   = $urandom;
            end
            hs.es_to_ms_valid = ($urandom_range(0, 2) != 0);
            hs.es_to_ms_bus   = cur;
            #2;
            if (hs.ms_to_ws_valid && hs.ws_allowin) begin
                chk("rnd_out_expected", 73'(expq.size() != 0), 73'(1));
                if (expq.size() != 0) chk("rnd_out", hs.ms_to_ws_bus, expq.pop_front());
            end
            if (hs.es_to_ms_valid && hs.ms_allowin) begin
                expq.push_back(model(cur, cur_rd));
                if (cur.is_mem) respq.push_back(cur_rd);
                cur    = rnd_entry();
                cur_rd = $urandom;
            end
            cyc();
        end

        hs.es_to_ms_valid = 1'b0;
        hs.ws_allowin     = 1'b1;
        for (int c = 0; c < 100 && expq.size() != 0; c++) begin
            hs.data_sram_data_ok = (respq.size() != 0);
            hs.data_sram_rdata   = (respq.size() != 0) ? respq.pop_front() : 32'h0;
            #2;
            if (hs.ms_to_ws_valid) begin
                chk("drain_out_expected", 73'(expq.size() != 0), 73'(1));
                if (expq.size() != 0) chk("drain_out", hs.ms_to_ws_bus, expq.pop_front());
            end
            cyc();
        end
        hs.data_sram_data_ok = 1'b0;
        chk("drain_empty", 73'(expq.size()), 73'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
